// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: program-counter and branch-resolution stage.
//   Resolves ARM branches from the branch_ext offset: target = br_pc + 8 + ext_ofst.
//   A taken branch redirects the fetch PC and pulses the LR write strobe for BL.
//   It also raises flush for FLUSH_CYCLES non-stalled cycles to squash wrong-path work.
// Ports:
//   clk, reset (sync, active-high)       clock and reset
//   stall                                hold all state; LR strobe forced low
//   br_valid, br_link, br_cond_pass      branch present / L bit / condition met
//   br_pc, ext_ofst                      branch address and sign-extended offset<<2
//   pc, flush, lr_we, lr_data            registered fetch PC, squash, LR write port
//   busy                                 combinational, high while in FLUSH
// Optional feature macro: BRANCH_STATS_EN
//   Adds the br_taken_cnt and br_nt_cnt 16-bit accepted-branch counters.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_link,
  input  logic        br_cond_pass,
  input  logic [31:0] br_pc,
  input  logic [31:0] ext_ofst,
  output logic [31:0] pc,
  output logic        flush,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_taken_cnt,
  output logic [15:0] br_nt_cnt
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_d, lr_data_d;
  logic              flush_d, lr_we_d;
  logic [XLEN-1:0]   target_c, link_c;

  // Branch arithmetic, modulo 2^32
  assign target_c = br_pc + XLEN'(32'd8) + ext_ofst;
  assign link_c   = br_pc + XLEN'(32'd4);

  assign busy = (state_q == FLUSH);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc      <= RESET_PC;
      flush   <= 1'b0;
      lr_we   <= 1'b0;
      lr_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc      <= pc_d;
      flush   <= flush_d;
      lr_we   <= lr_we_d;
      lr_data <= lr_data_d;
    end
  end

  // Next-state and next-output logic; stall holds everything except lr_we
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc;
    flush_d   = flush;
    lr_we_d   = 1'b0;
    lr_data_d = lr_data;
    if (!stall) begin
      unique case (state_q)
        RUN: begin
          pc_d    = pc + XLEN'(32'd4);
          flush_d = 1'b0;
          if (br_valid && br_cond_pass) begin
            pc_d    = target_c;
            flush_d = 1'b1;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            // A single-cycle flush is fully covered by the redirect cycle
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            if (br_link) begin
              lr_we_d   = 1'b1;
              lr_data_d = link_c;
            end
          end
        end
        FLUSH: begin
          // Wrong-path branches are ignored here
          pc_d = pc + XLEN'(32'd4);
          if (cnt_q == '0) begin
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            flush_d = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Accepted-branch statistics, wrapping 16-bit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      br_taken_cnt <= '0;
      br_nt_cnt    <= '0;
    end else if (!stall && state_q == RUN && br_valid) begin
      if (br_cond_pass) br_taken_cnt <= br_taken_cnt + 16'd1;
      else              br_nt_cnt    <= br_nt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int unsigned FC  = 2;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, br_link, br_cond_pass;
  logic [31:0] br_pc, ext_ofst;
  logic [31:0] pc, lr_data;
  logic        flush, lr_we, busy;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_taken_cnt, br_nt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_pc_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_link(br_link), .br_cond_pass(br_cond_pass), .br_pc(br_pc),
    .ext_ofst(ext_ofst), .pc(pc), .flush(flush), .lr_we(lr_we),
    .lr_data(lr_data), .busy(busy)
`ifdef BRANCH_STATS_EN
    , .br_taken_cnt(br_taken_cnt), .br_nt_cnt(br_nt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks how many flush cycles remain in the current window
  logic [31:0] m_pc, m_lr_data;
  logic        m_lr_we;
  int          m_left;
  bit          m_valid = 1'b0;
  int          m_taken, m_nt;

  function automatic bit m_busy();
    return (m_left > 0) && (FC > 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RPC; m_left = 0; m_lr_we = 1'b0; m_lr_data = 32'h0;
      m_taken = 0; m_nt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_lr_we = 1'b0;
      if (!stall) begin
        if (!m_busy() && br_valid && br_cond_pass) begin
          m_pc   = br_pc + 32'd8 + ext_ofst;
          m_left = FC;
          m_taken = (m_taken + 1) % 65536;
          if (br_link) begin
            m_lr_we = 1'b1; m_lr_data = br_pc + 32'd4;
          end
        end else begin
          if (!m_busy() && br_valid) m_nt = (m_nt + 1) % 65536;
          m_pc = m_pc + 32'd4;
          if (m_left > 0) m_left = m_left - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pc",      pc,               m_pc);
      chk("m_flush",   32'(flush),       32'(m_left > 0));
      chk("m_busy",    32'(busy),        32'(m_busy()));
      chk("m_lr_we",   32'(lr_we),       32'(m_lr_we));
      chk("m_lr_data", lr_data,          m_lr_data);
`ifdef BRANCH_STATS_EN
      chk("m_taken",   32'(br_taken_cnt), 32'(m_taken));
      chk("m_nt",      32'(br_nt_cnt),    32'(m_nt));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic br(input logic v, input logic c, input logic l,
                    input logic [31:0] bpc, input logic [31:0] ofs);
    br_valid = v; br_cond_pass = c; br_link = l; br_pc = bpc; ext_ofst = ofs;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(2);
    chk("rst_pc", pc, 32'h100);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_lr_we", 32'(lr_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step(1); chk("run_pc0", pc, 32'h104);
    step(1); chk("run_pc1", pc, 32'h108);
    step(1); chk("run_pc2", pc, 32'h10C);

    // Taken BL with a negative offset
    br(1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hFF55_5554);
    step(1);
    chk("bl_pc", pc, 32'hFF55_655C);
    chk("bl_lr_we", 32'(lr_we), 32'h1);
    chk("bl_lr_data", lr_data, 32'h0000_1004);
    chk("bl_flush", 32'(flush), 32'h1);
    br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    chk("bl_pc1", pc, 32'hFF55_6560);
    chk("bl_lr_we1", 32'(lr_we), 32'h0);
    chk("bl_flush1", 32'(flush), 32'h1);
    step(1);
    chk("bl_flush2", 32'(flush), 32'h0);
    chk("bl_busy2", 32'(busy), 32'h0);

    // Not taken: link ignored
    br(1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hFF55_5554);
    step(1);
    chk("nt_pc", pc, 32'hFF55_6568);
    chk("nt_flush", 32'(flush), 32'h0);
    chk("nt_lr_we", 32'(lr_we), 32'h0);

    // Wrap-around target, then wrong-path taken branches during FLUSH
    br(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0010);
    step(1); chk("wrap_pc", pc, 32'h0000_0010);
    br(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0100);
    step(1); chk("wp_pc0", pc, 32'h14); chk("wp_lr_we", 32'(lr_we), 32'h0);
    step(1); chk("wp_pc1", pc, 32'h18); chk("wp_busy", 32'(busy), 32'h0);

    // Branch right after returning to RUN is accepted
    br(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000);
    step(1); chk("b2b_pc", pc, 32'h208);
    br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Stall during FLUSH holds everything
    stall = 1'b1;
    step(3);
    chk("st_pc", pc, 32'h208);
    chk("st_flush", 32'(flush), 32'h1);
    chk("st_busy", 32'(busy), 32'h1);
    stall = 1'b0;
    step(1); chk("st_pc1", pc, 32'h20C); chk("st_busy1", 32'(busy), 32'h1);

    // Reset mid-flush
    reset = 1'b1;
    step(1);
    chk("mr_pc", pc, 32'h100);
    chk("mr_flush", 32'(flush), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
`ifdef BRANCH_STATS_EN
    chk("mr_taken", 32'(br_taken_cnt), 32'h0);
`endif
    reset = 1'b0;

    // BL then stall: strobe must not repeat; stalled branch in RUN not accepted
    br(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0008);
    step(1); chk("bls_pc", pc, 32'h50); chk("bls_we", 32'(lr_we), 32'h1);
    stall = 1'b1;
    step(1); chk("bls_we1", 32'(lr_we), 32'h0); chk("bls_pc1", pc, 32'h50);
    stall = 1'b0; br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(3);
    stall = 1'b1; br(1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h0);
    step(2); chk("stall_br_pc", pc, 32'h5C);
    stall = 1'b0; br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Mixed stimulus checked by the model
    for (int i = 0; i < 200; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      br(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom, {{6{1'b0}}, 24'($urandom), 2'b00});
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
